// File: rtl/irq_pkg.sv
// irq_pkg -- shared definitions for the interrupt controller slice.
//   irq_state_e  : controller FSM state (IDLE / REQ / SERVICE)
//   NSRC_DEFAULT : default number of external interrupt sources
package irq_pkg;

  localparam int NSRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if -- bundle of the interrupt controller's device/core signals.
//   IrqSrc   : raw device interrupt lines (synchronous to clk)
//   MaskWe   : enable register write strobe
//   MaskIn   : new enable register value (1 = enabled)
//   ExtIAck  : core has taken the exception
//   ERet     : handler finished (ERET retired)
//   ExtIRQ   : interrupt request to the core
//   IrqId    : index of the source requested / in service
//   Pending  : pending register
//   Busy     : controller is in SERVICE
// Modports: master = core/device side, slave = controller side.
interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
);
  logic [NSRC-1:0] IrqSrc;
  logic            MaskWe;
  logic [NSRC-1:0] MaskIn;
  logic            ExtIAck;
  logic            ERet;
  logic            ExtIRQ;
  logic [IDW-1:0]  IrqId;
  logic [NSRC-1:0] Pending;
  logic            Busy;

  modport master (
    output IrqSrc, MaskWe, MaskIn, ExtIAck, ERet,
    input  ExtIRQ, IrqId, Pending, Busy
  );

  modport slave (
    input  IrqSrc, MaskWe, MaskIn, ExtIAck, ERet,
    output ExtIRQ, IrqId, Pending, Busy
  );
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- combinational lowest-index-first priority encoder.
//   req_i   : request vector (NSRC bits)
//   id_o    : index of the lowest set bit (0 when none set)
//   valid_o : at least one request bit set
module irq_prio_enc #(
  parameter int NSRC = 4,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req_i,
  output logic [IDW-1:0]  id_o,
  output logic            valid_o
);

  logic [NSRC-1:0] lowest_s;

  // Isolate the lowest set bit, then OR-encode its index (one-hot, so OR is exact).
  always_comb begin
    lowest_s = req_i & (~req_i + {{(NSRC-1){1'b0}}, 1'b1});
    id_o     = {IDW{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      id_o = id_o | (lowest_s[i] ? IDW'(i) : {IDW{1'b0}});
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl -- single-level (non-nesting) external interrupt controller.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : irq_ctrl_if.slave (IrqSrc, MaskWe, MaskIn, ExtIAck, ERet in;
//           ExtIRQ, IrqId, Pending, Busy out)
// Build option: define IRQ_EDGE_DETECT_EN for rising-edge source detection
// (one-cycle history register); default build detects sources by level.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic       clk,
  input  logic       reset,
  irq_ctrl_if.slave  bus
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic            ext_irq_q, ext_irq_d;
  logic            busy_q, busy_d;

  logic [NSRC-1:0] detect_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] cand_s;
  logic [IDW-1:0]  enc_id_s;
  logic            enc_valid_s;

  function automatic logic [NSRC-1:0] id_to_mask(input logic [IDW-1:0] id);
    logic [NSRC-1:0] m;
    m     = {NSRC{1'b0}};
    m[id] = 1'b1;
    return m;
  endfunction

`ifdef IRQ_EDGE_DETECT_EN
  logic [NSRC-1:0] src_hist_q;

  // Previous-cycle copy of the source lines for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_hist_q <= {NSRC{1'b0}};
    end else begin
      src_hist_q <= bus.IrqSrc;
    end
  end

  // A source is detected only on its 0->1 transition.
  always_comb begin
    detect_s = bus.IrqSrc & ~src_hist_q;
  end
`else
  // A source is detected on every cycle its line is high.
  always_comb begin
    detect_s = bus.IrqSrc;
  end
`endif

  assign cand_s = pending_q & enable_q;

  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .req_i   (cand_s),
    .id_o    (enc_id_s),
    .valid_o (enc_valid_s)
  );

  // Next-state logic: FSM, pending set/clear, enable register load.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_s    = {NSRC{1'b0}};
    case (state_q)
      IDLE: begin
        if (enc_valid_s) begin
          state_d  = REQ;
          irq_id_d = enc_id_s;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        // Request and id are frozen until the core acknowledges.
        if (bus.ExtIAck) begin
          state_d = SERVICE;
          clr_s   = id_to_mask(irq_id_q);
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (bus.ERet) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // New detections win over the acknowledge clear on the same edge.
    pending_d = (pending_q & ~clr_s) | detect_s;

    if (bus.MaskWe) begin
      enable_d = bus.MaskIn;
    end else begin
      enable_d = enable_q;
    end

    ext_irq_d = (state_d == REQ);
    busy_d    = (state_d == SERVICE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= {NSRC{1'b0}};
      enable_q  <= {NSRC{1'b0}};
      irq_id_q  <= {IDW{1'b0}};
      ext_irq_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_id_q  <= irq_id_d;
      ext_irq_q <= ext_irq_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ExtIRQ  = ext_irq_q;
  assign bus.IrqId   = irq_id_q;
  assign bus.Pending = pending_q;
  assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl -- self-checking bench for irq_ctrl (NSRC=4).
module tb_irq_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  irq_ctrl_if #(.NSRC(4), .IDW(2)) bus ();

  irq_ctrl #(.NSRC(4), .IDW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0] src;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       ack;
    logic       eret;
    logic       exp_irq;
    logic [1:0] exp_id;
    logic [3:0] exp_pend;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [3:0] src, input logic we, input logic [3:0] min,
                              input logic ack, input logic eret, input logic irq,
                              input logic [1:0] id, input logic [3:0] pend, input logic busy);
    vec_t v;
    v.src = src; v.mask_we = we; v.mask_in = min; v.ack = ack; v.eret = eret;
    v.exp_irq = irq; v.exp_id = id; v.exp_pend = pend; v.exp_busy = busy;
    return v;
  endfunction

  task automatic push_exp(input logic irq, input logic [1:0] id, input logic [3:0] pend,
                          input logic busy);
    exp_t e;
    e.irq = irq; e.id = id; e.pend = pend; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry in scoreboard", name);
    end else begin
      e = sb.pop_front();
      if (bus.ExtIRQ !== e.irq || bus.IrqId !== e.id || bus.Pending !== e.pend ||
          bus.Busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got irq=%0b id=%0d pend=%b busy=%0b, expected irq=%0b id=%0d pend=%b busy=%0b",
                 name, bus.ExtIRQ, bus.IrqId, bus.Pending, bus.Busy, e.irq, e.id, e.pend, e.busy);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    bus.IrqSrc  = v.src;
    bus.MaskWe  = v.mask_we;
    bus.MaskIn  = v.mask_in;
    bus.ExtIAck = v.ack;
    bus.ERet    = v.eret;
    push_exp(v.exp_irq, v.exp_id, v.exp_pend, v.exp_busy);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic idle_inputs();
    bus.IrqSrc = 4'b0000; bus.MaskWe = 1'b0; bus.MaskIn = 4'b0000;
    bus.ExtIAck = 1'b0; bus.ERet = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         rises;
    int         exp_rises;
    logic       prev_irq;
    logic       ack_n;
    logic       eret_n;

    // Main function table: {src, we, mask_in, ack, eret} -> {irq, id, pend, busy}
    tbl.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0011, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0));

    // Reset state
    reset = 1'b1;
    idle_inputs();
    #1;
    push_exp(1'b0, 2'd0, 4'b0000, 1'b0);
    check("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Reach SERVICE on source 2, then assert reset between clock edges.
    apply(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0), "svc_en");
    apply(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0100, 1'b0), "svc_pulse");
    apply(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0), "svc_req");
    apply(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1), "svc_ack");
    idle_inputs();
    bus.IrqSrc = 4'b1000;
    #1;
    reset = 1'b1;
    #1;
    push_exp(1'b0, 2'd0, 4'b0000, 1'b0);
    check("reset_async");
    bus.IrqSrc = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // First edge after reset samples normally; enable must have been cleared.
    apply(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0), "first_edge");
    apply(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0), "enable_cleared");

    // Source 0 held high for 10 cycles with a responsive core.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    apply(mk(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0), "hold_setup");
    rises    = 0;
    prev_irq = 1'b0;
    ack_n    = 1'b0;
    eret_n   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.IrqSrc  = (c < 10) ? 4'b0001 : 4'b0000;
      bus.MaskWe  = 1'b0;
      bus.ExtIAck = ack_n;
      bus.ERet    = eret_n;
      @(posedge clk);
      #1;
      if (bus.ExtIRQ && !prev_irq) rises++;
      prev_irq = bus.ExtIRQ;
      ack_n    = bus.ExtIRQ;
      eret_n   = bus.Busy;
    end
`ifdef IRQ_EDGE_DETECT_EN
    exp_rises = 1;
`else
    exp_rises = 4;
`endif
    n_tests++;
    if (rises != exp_rises) begin
      n_fail++;
      $display("FAIL hold_requests: got %0d requests, expected %0d", rises, exp_rises);
    end
    push_exp(1'b0, 2'd0, 4'b0000, 1'b0);
    check("hold_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4, number of external interrupt sources (2..16).
REQ-002 Parameter IDW, default $clog2(NSRC), width of source identifier.
REQ-003 clk  input  1  single system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IrqSrc  input  NSRC  raw device interrupt lines, already synchronous to clk.
REQ-006 MaskWe  input  1  write strobe for enable register.
REQ-007 MaskIn  input  NSRC  new enable register value (1 = source enabled).
REQ-008 ExtIAck  input  1  acknowledge from main decoder; core has taken the exception.
REQ-009 ERet  input  1  ERET retired; handler finished.
REQ-010 ExtIRQ  output  1  interrupt request to main decoder.
REQ-011 IrqId  output  IDW  index of source being requested/serviced.
REQ-012 Pending  output  NSRC  pending register, readable by core.
REQ-013 Busy  output  1  high while in SERVICE state.

Function
REQ-014 FSM states SHALL be IDLE, REQ, SERVICE; ExtIRQ SHALL be high iff state is REQ; Busy SHALL be high iff state is SERVICE.
REQ-015 Pending[i] SHALL set at the clock edge where source i is detected (REQ-032); set SHALL take priority over clear in the same cycle.
REQ-016 Enable register SHALL load MaskIn on the edge where MaskWe=1; no other effect on FSM.
REQ-017 IDLE: if (Pending & Enable) != 0, SHALL move to REQ at the next edge and latch IrqId = lowest-numbered set bit of (Pending & Enable).
REQ-018 Latency: pending set at edge k with source enabled and FSM idle -> ExtIRQ high after edge k+1.
REQ-019 REQ: ExtIRQ and IrqId SHALL be held stable until ExtIAck=1, regardless of mask changes or new pending bits.
REQ-020 REQ with ExtIAck=1: SHALL clear Pending[IrqId] and move to SERVICE at the same edge; ExtIRQ low in the following cycle.
REQ-021 SERVICE: SHALL not raise ExtIRQ (no nesting); on ERet=1 SHALL move to IDLE; IrqId held until then.
REQ-022 ERet in IDLE or REQ SHALL be ignored; ExtIAck in IDLE or SERVICE SHALL be ignored.
REQ-023 Same source re-asserted on the ack edge SHALL leave Pending[IrqId]=1 and re-request after ERet.
REQ-024 Masked pending bits SHALL remain pending and SHALL be requested once enabled while IDLE.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, Pending=0, Enable=0, IrqId=0, ExtIRQ=0, Busy=0, edge-history register=0.
REQ-026 Reset asserted in REQ or SERVICE SHALL abandon the request; no ack or ERet is required afterwards.
REQ-027 First edge after reset deassertion SHALL sample IrqSrc normally.

Configuration
REQ-028 Macro IRQ_EDGE_DETECT_EN selects source detection mode.
REQ-029 With IRQ_EDGE_DETECT_EN defined: source i detected when IrqSrc[i]=1 and previous-cycle IrqSrc[i]=0 (one-cycle history register).
REQ-030 Without it: source i detected whenever IrqSrc[i]=1 (level); history register SHALL not exist.
REQ-031 FSM, handshake and latency relative to detection SHALL be identical in both builds.
REQ-032 "Detected" in REQ-015 SHALL mean per REQ-029/REQ-030.

Structure
REQ-033 Shared package irq_pkg SHALL hold the FSM state typedef (IDLE/REQ/SERVICE) and default NSRC constant.
REQ-034 Sub-module irq_prio_enc SHALL be a combinational lowest-index-first priority encoder (NSRC in, IDW out, valid flag).

Verification
REQ-035 Enable=4'b1111, pulse IrqSrc[2] one cycle at edge k -> Pending=4'b0100, ExtIRQ=1 after k+1, IrqId=2; ExtIAck -> Pending=0, Busy=1; ERet -> IDLE.
REQ-036 Sources 1 and 3 pending together -> IrqId=1 first; after ack+ERet, IrqId=3 requested next cycle.
REQ-037 Enable=0, pulse source 0 -> Pending=4'b0001, ExtIRQ=0; write MaskIn=4'b0001 -> ExtIRQ=1 two edges later.
REQ-038 In REQ, write MaskIn=0 and pulse source 0 -> ExtIRQ stays 1, IrqId unchanged until ExtIAck.
REQ-039 Assert reset during SERVICE -> Pending=0, Enable=0, ExtIRQ=0, Busy=0 immediately, without a clock edge.
REQ-040 Hold IrqSrc[0]=1 for 10 cycles: edge build -> exactly one request; level build -> re-request after every ERet.
